goertzel_tone_detector: RTL and testbench

//  Single-bin AC measurement receiver: consumes a sampled response stream (e.g. bandpass filter output)
//  and returns the squared magnitude |X(k)|^2 of one frequency bin over a block of N samples.

---
 rtl/goertzel_tone_detector_if.sv | 30 +++
 rtl/goertzel_tone_detector.sv | 178 +++++++++++++++++
 tb/tb_goertzel_tone_detector.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/goertzel_tone_detector_if.sv
// Goertzel tone detector bus: block control, sample stream and result handshake.
// master drives start/coef/block_len/in_*/res_ready; slave returns status and result.
interface goertzel_tone_detector_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 16
);
    logic                      start;
    logic signed [COEF_W-1:0]  coef;
    logic        [LEN_W-1:0]   block_len;
    logic                      in_valid;
    logic signed [DATA_W-1:0]  in_data;
    logic                      in_ready;
    logic                      busy;
    logic                      cfg_err;
    logic                      res_valid;
    logic                      res_ready;
    logic        [2*ACC_W-1:0] res_power;

    modport master (
        output start, coef, block_len, in_valid, in_data, res_ready,
        input  in_ready, busy, cfg_err, res_valid, res_power
    );

    modport slave (
        input  start, coef, block_len, in_valid, in_data, res_ready,
        output in_ready, busy, cfg_err, res_valid, res_power
    );
endinterface

// File: rtl/goertzel_tone_detector.sv
// Single-bin Goertzel receiver: returns |X(k)|^2 of one bin over an N-sample block.
// Ports: clk, rst_n (sync, active low), bus (slave side of goertzel_tone_detector_if).
module goertzel_tone_detector #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 15,
    parameter int ACC_W     = 40,
    parameter int LEN_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    goertzel_tone_detector_if.slave   bus
);
    localparam int PROD_W = COEF_W + ACC_W;
    localparam int T_W    = PROD_W - COEF_FRAC;
    localparam int S0_W   = T_W + 2;
    localparam int SQ_W   = 2 * ACC_W;
    localparam int PC_W   = T_W + ACC_W;
    localparam int SUM_W  = PC_W + 2;

    typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               ph_q, ph_d;
    logic signed [COEF_W-1:0] coef_q, coef_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  s1_q, s1_d;
    logic signed [ACC_W-1:0]  s2_q, s2_d;
    logic signed [SQ_W-1:0]   pa_q, pa_d;
    logic signed [SQ_W-1:0]   pb_q, pb_d;
    logic [SQ_W-1:0]          res_q, res_d;
    logic                     cfg_err_q, cfg_err_d;

    logic signed [PROD_W-1:0] cprod;
    logic signed [T_W-1:0]    tcoef;
    logic signed [S0_W-1:0]   s0w;
    logic [S0_W-ACC_W:0]      s0_hi;
    logic signed [ACC_W-1:0]  s0;
    logic signed [T_W-1:0]    op_a;
    logic signed [ACC_W-1:0]  op_b;
    logic signed [PC_W-1:0]   mprod;
    logic signed [SUM_W-1:0]  sum;

    // Dropping the low COEF_FRAC bits of a two's complement product is a floor shift.
    assign cprod = PROD_W'(coef_q) * PROD_W'(s1_q);
    assign tcoef = $signed(cprod[PROD_W-1:COEF_FRAC]);
    assign s0w   = S0_W'(bus.in_data) + S0_W'(tcoef) - S0_W'(s2_q);
    assign s0_hi = s0w[S0_W-1:ACC_W-1];

    // Saturate: in range only if every bit above the result sign matches it.
    always_comb begin
        s0 = s0w[ACC_W-1:0];
        if (!((&s0_hi) || !(|s0_hi))) begin
            s0 = s0w[S0_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // One shared multiplier walks the three energy terms in CALC.
    always_comb begin
        op_a = T_W'(s1_q);
        op_b = s1_q;
        unique case (ph_q)
            2'd1: begin
                op_a = T_W'(s2_q);
                op_b = s2_q;
            end
            2'd2: begin
                op_a = tcoef;
                op_b = s2_q;
            end
            default: ;
        endcase
    end

    assign mprod = PC_W'(op_a) * PC_W'(op_b);
    assign sum   = SUM_W'(pa_q) + SUM_W'(pb_q) - SUM_W'(mprod);

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        coef_d    = coef_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        pa_d      = pa_q;
        pb_d      = pb_q;
        res_d     = res_q;
        cfg_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.block_len != '0) begin
                        coef_d  = bus.coef;
                        len_d   = bus.block_len;
                        s1_d    = '0;
                        s2_d    = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    s2_d  = s1_q;
                    s1_d  = s0;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = CALC;
                        ph_d    = 2'd0;
                    end
                end
            end
            CALC: begin
                ph_d = ph_q + 2'd1;
                unique case (ph_q)
                    2'd0: pa_d = mprod[SQ_W-1:0];
                    2'd1: pb_d = mprod[SQ_W-1:0];
                    default: begin
                        if (sum[SUM_W-1]) begin
                            res_d = '0;
                        end else if (|sum[SUM_W-2:SQ_W]) begin
                            res_d = '1;
                        end else begin
                            res_d = sum[SQ_W-1:0];
                        end
                        ph_d    = 2'd0;
                        state_d = DONE;
                    end
                endcase
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            coef_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            pa_q      <= '0;
            pb_q      <= '0;
            res_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            coef_q    <= coef_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            pa_q      <= pa_d;
            pb_q      <= pb_d;
            res_q     <= res_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.res_power = res_q;
endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Bench for goertzel_tone_detector: scenario tasks against a Goertzel reference model.
// Drives and samples on the falling clock edge.
module tb_goertzel_tone_detector;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;

    int          smp[$];
    int          last_t;
    int          got_lat;
    logic [79:0] got_pow;
    bit          got_ok;
    bit          cfg_seen;

    goertzel_tone_detector_if bus ();

    goertzel_tone_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference Goertzel recursion and energy with clamped 40-bit state.
    function automatic logic [79:0] model(input int c, input int n);
        longint s1 = 0;
        longint s2 = 0;
        longint s0;
        longint t;
        longint maxv = 64'sd549755813887;
        longint minv = -64'sd549755813888;
        logic signed [127:0] a, b, tt, p;
        for (int i = 0; i < n; i++) begin
            t  = (longint'(c) * s1) >>> 15;
            s0 = longint'(smp[i]) + t - s2;
            if (s0 > maxv) s0 = maxv;
            if (s0 < minv) s0 = minv;
            s2 = s1;
            s1 = s0;
        end
        a  = 128'(s1);
        b  = 128'(s2);
        tt = 128'((longint'(c) * s1) >>> 15);
        p  = a * a + b * b - tt * b;
        if (p < 0) return '0;
        if (p[127:80] != '0) return '1;
        return p[79:0];
    endfunction

    task automatic do_start(input int c, input int n);
        logic [31:0] cv;
        cv            = c;
        bus.start     = 1'b1;
        bus.coef      = cv[17:0];
        bus.block_len = n[15:0];
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic feed(input int stall, input int glitch_at);
        int i = 0;
        int guard = 0;
        int n = smp.size();
        cfg_seen = 1'b0;
        while (i < n && guard < n * 20 + 100) begin
            if (bus.cfg_err) cfg_seen = 1'b1;
            bus.start = 1'b0;
            if (i == glitch_at) begin
                bus.start     = 1'b1;
                bus.coef      = '0;
                bus.block_len = '0;
            end
            if (bus.in_ready && $urandom_range(0, 99) >= stall) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'(smp[i]);
                last_t       = cyc;
                i++;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (bus.cfg_err) cfg_seen = 1'b1;
    endtask

    task automatic wait_res();
        int k = 0;
        got_ok  = 1'b0;
        got_lat = -1;
        got_pow = '0;
        while (!got_ok && k < 40) begin
            if (bus.res_valid) begin
                got_ok  = 1'b1;
                got_lat = cyc - last_t;
                got_pow = bus.res_power;
            end else begin
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic ack(input bit also_start);
        bus.res_ready = 1'b1;
        bus.start     = also_start;
        bus.block_len = 16'd8;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic fill(input int v, input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(v);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.in_ready, bus.busy, bus.cfg_err, bus.res_valid, bus.res_power} !== '0) begin
            $display("FAIL reset_outputs got %0h want 0",
                     {bus.in_ready, bus.busy, bus.cfg_err, bus.res_valid, bus.res_power});
        end else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dc();
        fill(100, 8);
        do_start(65536, 8);
        feed(0, -1);
        wait_res();
        n_total++;
        if (got_pow !== 80'd640000) $display("FAIL dc_power got %0d want 640000", got_pow);
        else n_pass++;
        n_total++;
        if (got_lat !== 4) $display("FAIL dc_latency got %0d want 4", got_lat);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b0) $display("FAIL dc_in_ready_done got %0b want 0", bus.in_ready);
        else n_pass++;
        ack(1'b0);
        n_total++;
        if ({bus.busy, bus.res_valid} !== 2'b00) begin
            $display("FAIL dc_idle got busy/valid %0b want 00", {bus.busy, bus.res_valid});
        end else n_pass++;
    endtask

    task automatic test_nyquist_zero();
        int c;
        smp.delete();
        for (int i = 0; i < 8; i++) smp.push_back((i % 2 == 0) ? 100 : -100);
        do_start(-65536, 8);
        feed(0, -1);
        wait_res();
        n_total++;
        if (got_pow !== 80'd640000) $display("FAIL nyquist_power got %0d want 640000", got_pow);
        else n_pass++;
        ack(1'b0);
        fill(0, 8);
        c = int'($urandom_range(0, 262143)) - 131072;
        do_start(c, 8);
        feed(0, -1);
        wait_res();
        n_total++;
        if (got_pow !== 80'd0) $display("FAIL zero_power got %0d want 0", got_pow);
        else n_pass++;
        ack(1'b0);
    endtask

    task automatic test_fs4_backpressure();
        bit stable = 1'b1;
        int pat[4] = '{100, 0, -100, 0};
        smp.delete();
        for (int i = 0; i < 8; i++) smp.push_back(pat[i % 4]);
        do_start(0, 8);
        feed(0, -1);
        wait_res();
        n_total++;
        if (got_pow !== 80'd160000) $display("FAIL fs4_power got %0d want 160000", got_pow);
        else n_pass++;
        repeat (10) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_power !== 80'd160000) stable = 1'b0;
        end
        n_total++;
        if (!stable) $display("FAIL fs4_hold got %0d want 160000 held", bus.res_power);
        else n_pass++;
        ack(1'b0);
        n_total++;
        if ({bus.busy, bus.res_valid} !== 2'b00) begin
            $display("FAIL fs4_release got busy/valid %0b want 00", {bus.busy, bus.res_valid});
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.res_valid !== 1'b0) $display("FAIL fs4_single got %0b want 0", bus.res_valid);
        else n_pass++;
    endtask

    task automatic test_stalls();
        n_total++;
        if (bus.in_ready !== 1'b0) $display("FAIL idle_in_ready got %0b want 0", bus.in_ready);
        else n_pass++;
        fill(100, 8);
        do_start(65536, 8);
        feed(40, -1);
        wait_res();
        n_total++;
        if (got_pow !== 80'd640000) $display("FAIL stall_power got %0d want 640000", got_pow);
        else n_pass++;
        n_total++;
        if (got_lat !== 4) $display("FAIL stall_latency got %0d want 4", got_lat);
        else n_pass++;
        ack(1'b0);
    endtask

    task automatic test_control();
        bus.start     = 1'b1;
        bus.block_len = '0;
        @(negedge clk);
        bus.start = 1'b0;
        n_total++;
        if ({bus.cfg_err, bus.busy} !== 2'b10) begin
            $display("FAIL cfg_err_pulse got err/busy %0b want 10", {bus.cfg_err, bus.busy});
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.cfg_err, bus.busy} !== 2'b00) begin
            $display("FAIL cfg_err_clear got err/busy %0b want 00", {bus.cfg_err, bus.busy});
        end else n_pass++;
        fill(100, 8);
        do_start(65536, 8);
        feed(0, 3);
        wait_res();
        n_total++;
        if (got_pow !== 80'd640000) $display("FAIL busy_start_power got %0d want 640000", got_pow);
        else n_pass++;
        n_total++;
        if (cfg_seen !== 1'b0) $display("FAIL busy_start_cfg_err got %0b want 0", cfg_seen);
        else n_pass++;
        ack(1'b1);
        n_total++;
        if ({bus.busy, bus.cfg_err} !== 2'b00) begin
            $display("FAIL ack_start got busy/err %0b want 00", {bus.busy, bus.cfg_err});
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        fill(100, 3);
        do_start(65536, 8);
        feed(0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if ({bus.in_ready, bus.busy, bus.cfg_err, bus.res_valid, bus.res_power} !== '0) begin
            $display("FAIL midreset_outputs got %0h want 0",
                     {bus.in_ready, bus.busy, bus.cfg_err, bus.res_valid, bus.res_power});
        end else n_pass++;
        @(negedge clk);
        fill(100, 8);
        do_start(65536, 8);
        feed(0, -1);
        wait_res();
        n_total++;
        if (got_pow !== 80'd640000) $display("FAIL midreset_power got %0d want 640000", got_pow);
        else n_pass++;
        ack(1'b0);
    endtask

    task automatic test_saturation();
        logic [79:0] exp_pow;
        fill(32767, 65535);
        exp_pow = model(65536, 65535);
        do_start(65536, 65535);
        feed(0, -1);
        wait_res();
        n_total++;
        if (got_pow !== exp_pow) $display("FAIL sat_power got %0d want %0d", got_pow, exp_pow);
        else n_pass++;
        n_total++;
        if (got_lat !== 4) $display("FAIL sat_latency got %0d want 4", got_lat);
        else n_pass++;
        ack(1'b0);
    endtask

    task automatic test_random();
        int c;
        int n;
        logic [79:0] exp_pow;
        for (int b = 0; b < 6; b++) begin
            c = int'($urandom_range(0, 262143)) - 131072;
            n = (b == 0) ? 1 : int'($urandom_range(2, 24));
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back(int'($urandom_range(0, 65535)) - 32768);
            exp_pow = model(c, n);
            do_start(c, n);
            feed(30, -1);
            wait_res();
            n_total++;
            if (got_pow !== exp_pow) begin
                $display("FAIL rand_power[%0d] got %0d want %0d", b, got_pow, exp_pow);
            end else n_pass++;
            n_total++;
            if (got_lat !== 4) $display("FAIL rand_latency[%0d] got %0d want 4", b, got_lat);
            else n_pass++;
            ack(1'b0);
        end
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        last_t        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.coef      = '0;
        bus.block_len = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_dc();
        test_nyquist_zero();
        test_fs4_backpressure();
        test_stalls();
        test_control();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
